ram_dp_clr: RTL and testbench

RAM_DP_CLR -- requirements
Module: ram_dp_clr

---
 rtl/ram_dp_clr.sv | 160 ++++++++++++++++
 tb/tb_ram_dp_clr.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_clr.sv
// Dual-port word RAM: port A read/write (CPU), port B read-only (video), with an
// optional power-up clear engine that zeroes the whole array after reset.
// Latency: 1 cycle on both read ports. Backpressure: none; while busy, port A writes are dropped.
//
// Parameters:
//   AW     address width in bits
//   DW     data width in bits
//   DEPTH  number of words, 1 .. 2**AW; addresses >= DEPTH read as 0 and are never written
//
// Ports:
//   clk, rst_n       single rising-edge clock, asynchronous active-low reset
//   ce, we, a1, din  port A chip enable, write enable, address, write data
//   dout1            port A registered read data (read-first on a same-address write)
//   re2, a2          port B read enable and address
//   dout2            port B registered read data (write-first bypass from port A)
//   busy             high while the clear engine owns the array
//
// Build option:
//   RAM_DP_CLR_CLEAR_EN  when defined, a clear engine writes zero to every word after
//                        reset release (DEPTH edges) and holds busy high meanwhile.
//                        When undefined, busy is tied low, the array is uninitialised
//                        and writes are accepted from the first edge after release.

module ram_dp_clr #(
  parameter int AW    = 10,
  parameter int DW    = 8,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          we,
  input  logic [AW-1:0] a1,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout1,
  input  logic          re2,
  input  logic [AW-1:0] a2,
  output logic [DW-1:0] dout2,
  output logic          busy
);

  // Index width into the storage array; addresses are range-checked against
  // DEPTH before the low bits are used, so the upper address bits only matter
  // for the range check.
  localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH can equal 2**AW, so the range comparison needs one extra bit.
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic          a1_ok;
  logic          a2_ok;
  logic [IW-1:0] a1_idx;
  logic [IW-1:0] a2_idx;
  logic          wr_en;
  logic          clr_we;
  logic [IW-1:0] clr_idx;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;

  assign a1_ok  = ({1'b0, a1} < DEPTH_L);
  assign a2_ok  = ({1'b0, a2} < DEPTH_L);
  assign a1_idx = a1[IW-1:0];
  assign a2_idx = a2[IW-1:0];

`ifdef RAM_DP_CLR_CLEAR_EN

  // ---------------------------------------------------------------------------
  // Clear engine: walks clr_addr from 0 to DEPTH-1, one word per edge, then
  // parks in READY until the next reset.
  // ---------------------------------------------------------------------------
  localparam logic [0:0]    ST_CLEAR  = 1'b0;
  localparam logic [0:0]    ST_READY  = 1'b1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [0:0]    state;
  logic [AW-1:0] clr_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else if (state == ST_CLEAR) begin
      if (clr_addr == LAST_ADDR) begin
        state <= ST_READY;
      end else begin
        clr_addr <= clr_addr + AW'(1);
      end
    end
  end

  // busy is still high during the edge that writes the last word, so a port A
  // write presented on that edge is dropped; writes land from the next edge.
  assign busy    = (state == ST_CLEAR);
  assign clr_we  = busy;
  assign clr_idx = clr_addr[IW-1:0];

`else

  assign busy    = 1'b0;
  assign clr_we  = 1'b0;
  assign clr_idx = '0;

`endif

  // Port A write: needs chip enable, an in-range address and the array not
  // owned by the clear engine. Dropped writes are not retried.
  assign wr_en = ce && we && a1_ok && !busy;

  // ---------------------------------------------------------------------------
  // Storage. No reset: contents are only initialised by the clear engine.
  // The clear engine and port A are mutually exclusive through busy, the
  // priority here just keeps a single write port.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_en) begin
      mem[a1_idx] <= din;
    end
  end

  // Out-of-range addresses read as zero.
  assign rd1 = a1_ok ? mem[a1_idx] : '0;
  assign rd2 = a2_ok ? mem[a2_idx] : '0;

  // ---------------------------------------------------------------------------
  // Port A read: every edge, independent of ce. The array is sampled before
  // the write on the same edge takes effect, giving read-first behaviour.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout1 <= '0;
    end else if (busy) begin
      dout1 <= '0;
    end else begin
      dout1 <= rd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Port B read: only when re2 is set, otherwise holds. A port A write to the
  // same address on the same edge is forwarded so the video side never sees
  // stale data for a word being updated.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout2 <= '0;
    end else if (busy) begin
      dout2 <= '0;
    end else if (re2) begin
      if (wr_en && (a2 == a1)) begin
        dout2 <= din;
      end else begin
        dout2 <= rd2;
      end
    end
  end

endmodule

// File: tb/tb_ram_dp_clr.sv
// Directed bench for ram_dp_clr with AW=5, DW=8, DEPTH=16 (addresses 16..31 out of range).
// Latency: all reads checked one edge after stimulus, sampled 1 time unit after the edge.
// Backpressure: busy is observed directly; clear-engine scenarios only in the clear-enabled build.

module tb_ram_dp_clr;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

`ifdef RAM_DP_CLR_CLEAR_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          ce;
  logic          we;
  logic [AW-1:0] a1;
  logic [DW-1:0] din;
  logic [DW-1:0] dout1;
  logic          re2;
  logic [AW-1:0] a2;
  logic [DW-1:0] dout2;
  logic          busy;

  int checks;
  int errors;

  ram_dp_clr #(
    .AW   (AW),
    .DW   (DW),
    .DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ce   (ce),
    .we   (we),
    .a1   (a1),
    .din  (din),
    .dout1(dout1),
    .re2  (re2),
    .a2   (a2),
    .dout2(dout2),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle away from it before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ce = 1'b1; we = 1'b1; a1 = 5'd1; din = 8'hEE; re2 = 1'b1; a2 = 5'd1;
    repeat (3) tick();
    checks++;
    if (dout1 !== 8'h00) begin errors++; $display("FAIL reset_dout1 got %h want %h", dout1, 8'h00); end
    checks++;
    if (dout2 !== 8'h00) begin errors++; $display("FAIL reset_dout2 got %h want %h", dout2, 8'h00); end
    checks++;
    if (busy !== BUSY_RST) begin errors++; $display("FAIL reset_busy got %b want %b", busy, BUSY_RST); end
    ce = 1'b0; we = 1'b0;
  endtask

`ifdef RAM_DP_CLR_CLEAR_EN
  task automatic test_clear();
    int n;
    rst_n = 1'b1;
    ce = 1'b1; we = 1'b1; a1 = 5'd0; din = 8'hFF; re2 = 1'b1; a2 = 5'd0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
      if (n == 5) begin
        checks++;
        if (dout1 !== 8'h00) begin errors++; $display("FAIL clear_dout1_busy got %h want %h", dout1, 8'h00); end
        checks++;
        if (dout2 !== 8'h00) begin errors++; $display("FAIL clear_dout2_busy got %h want %h", dout2, 8'h00); end
      end
    end
    checks++;
    if (n != 16) begin errors++; $display("FAIL clear_busy_edges got %0d want %0d", n, 16); end
    we = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      a1 = AW'(i);
      tick();
      checks++;
      if (dout1 !== 8'h00) begin errors++; $display("FAIL clear_word_%0d got %h want %h", i, dout1, 8'h00); end
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    rst_n = 1'b0;
    ce = 1'b0; we = 1'b0; re2 = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (9) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout1 !== 8'h00 || dout2 !== 8'h00) begin
      errors++; $display("FAIL midclr_douts got %h/%h want %h/%h", dout1, dout2, 8'h00, 8'h00);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midclr_busy got %b want %b", busy, 1'b1); end
    tick();
    rst_n = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 16) begin errors++; $display("FAIL midclr_busy_edges got %0d want %0d", n, 16); end
  endtask
`else
  task automatic test_write_first_edge();
    rst_n = 1'b1;
    ce = 1'b1; we = 1'b1; a1 = 5'd3; din = 8'h5A; re2 = 1'b0; a2 = 5'd3;
    tick();
    we = 1'b0; re2 = 1'b1;
    tick();
    checks++;
    if (dout1 !== 8'h5A) begin errors++; $display("FAIL first_edge_dout1 got %h want %h", dout1, 8'h5A); end
    checks++;
    if (dout2 !== 8'h5A) begin errors++; $display("FAIL first_edge_dout2 got %h want %h", dout2, 8'h5A); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL first_edge_busy got %b want %b", busy, 1'b0); end
  endtask
`endif

  task automatic test_read_first();
    ce = 1'b1; we = 1'b1; a1 = 5'd5; din = 8'h00; re2 = 1'b0;
    tick();
    din = 8'hA5;
    tick();
    checks++;
    if (dout1 !== 8'h00) begin errors++; $display("FAIL read_first_old got %h want %h", dout1, 8'h00); end
    we = 1'b0;
    tick();
    checks++;
    if (dout1 !== 8'hA5) begin errors++; $display("FAIL read_first_new got %h want %h", dout1, 8'hA5); end
  endtask

  task automatic test_bypass();
    ce = 1'b1; we = 1'b1; a1 = 5'd7; a2 = 5'd7; din = 8'h3C; re2 = 1'b1;
    tick();
    checks++;
    if (dout2 !== 8'h3C) begin errors++; $display("FAIL bypass_dout2 got %h want %h", dout2, 8'h3C); end
    we = 1'b0; a2 = 5'd5;
    tick();
    checks++;
    if (dout2 !== 8'hA5) begin errors++; $display("FAIL portb_read5 got %h want %h", dout2, 8'hA5); end
    a2 = 5'd7;
    tick();
    checks++;
    if (dout2 !== 8'h3C) begin errors++; $display("FAIL portb_read7 got %h want %h", dout2, 8'h3C); end
    checks++;
    if (dout1 !== 8'h3C) begin errors++; $display("FAIL porta_read7 got %h want %h", dout1, 8'h3C); end
  endtask

  task automatic test_hold();
    re2 = 1'b0; a2 = 5'd5;
    tick();
    checks++;
    if (dout2 !== 8'h3C) begin errors++; $display("FAIL hold_addr_change got %h want %h", dout2, 8'h3C); end
    ce = 1'b1; we = 1'b1; a1 = 5'd7; a2 = 5'd7; din = 8'hFF;
    tick();
    checks++;
    if (dout2 !== 8'h3C) begin errors++; $display("FAIL hold_no_bypass got %h want %h", dout2, 8'h3C); end
    we = 1'b0; a2 = 5'd0;
    tick();
    checks++;
    if (dout2 !== 8'h3C) begin errors++; $display("FAIL hold_again got %h want %h", dout2, 8'h3C); end
  endtask

  task automatic test_out_of_range();
    ce = 1'b1; we = 1'b1; a1 = 5'd4; din = 8'h11; re2 = 1'b0;
    tick();
    a1 = 5'd20; din = 8'hFF;
    tick();
    we = 1'b0; a1 = 5'd4;
    tick();
    checks++;
    if (dout1 !== 8'h11) begin errors++; $display("FAIL oor_no_alias got %h want %h", dout1, 8'h11); end
    a1 = 5'd20;
    tick();
    checks++;
    if (dout1 !== 8'h00) begin errors++; $display("FAIL oor_read_a got %h want %h", dout1, 8'h00); end
    re2 = 1'b1; a2 = 5'd20;
    tick();
    checks++;
    if (dout2 !== 8'h00) begin errors++; $display("FAIL oor_read_b got %h want %h", dout2, 8'h00); end
  endtask

  task automatic test_ce_gating();
    ce = 1'b1; we = 1'b1; a1 = 5'd3; din = 8'h5A; re2 = 1'b0;
    tick();
    ce = 1'b0; we = 1'b1; din = 8'h77; re2 = 1'b1; a2 = 5'd3;
    tick();
    checks++;
    if (dout1 !== 8'h5A) begin errors++; $display("FAIL ce0_read_a got %h want %h", dout1, 8'h5A); end
    checks++;
    if (dout2 !== 8'h5A) begin errors++; $display("FAIL ce0_no_bypass got %h want %h", dout2, 8'h5A); end
    we = 1'b0;
    tick();
    checks++;
    if (dout1 !== 8'h5A) begin errors++; $display("FAIL ce0_write_dropped got %h want %h", dout1, 8'h5A); end
    a1 = 5'd4;
    tick();
    checks++;
    if (dout1 !== 8'h11) begin errors++; $display("FAIL ce0_read_other got %h want %h", dout1, 8'h11); end
  endtask

  task automatic test_async_reset();
    ce = 1'b0; we = 1'b0; a1 = 5'd3; re2 = 1'b1; a2 = 5'd3;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout1 !== 8'h00) begin errors++; $display("FAIL async_dout1 got %h want %h", dout1, 8'h00); end
    checks++;
    if (dout2 !== 8'h00) begin errors++; $display("FAIL async_dout2 got %h want %h", dout2, 8'h00); end
    checks++;
    if (busy !== BUSY_RST) begin errors++; $display("FAIL async_busy got %b want %b", busy, BUSY_RST); end
    repeat (2) tick();
    checks++;
    if (dout1 !== 8'h00) begin errors++; $display("FAIL async_hold_dout1 got %h want %h", dout1, 8'h00); end
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    ce = 1'b0; we = 1'b0; a1 = '0; din = '0; re2 = 1'b0; a2 = '0;
    test_reset();
`ifdef RAM_DP_CLR_CLEAR_EN
    test_clear();
    test_reset_mid_clear();
`else
    test_write_first_edge();
`endif
    test_read_first();
    test_bypass();
    test_hold();
    test_out_of_range();
    test_ce_gating();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
